md5_compress: RTL and testbench
===============================

# md5_compress

Iterative MD5 compression engine that sits directly downstream of the message padding stage. It accepts one 512-bit padded block per request and runs the 64 MD5 steps over it, one step per clock by default. It then adds the result into the 128-bit chaining state and presents the running digest. Multi-block messages are hashed by issuing successive blocks with `first_block` low after the first.

## Interface

Parameters: none.

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request to compress `block_in`; sampled only while `ready`=1
- `first_block`  in  1  sampled with `start`: 1 = chain from IV, 0 = chain from current digest
- `block_in`  in  [0:511]  padded block, bit 0 = MSB of message byte 0 (same ordering the padding stage emits)
- `ready`  out  1  high in IDLE; start accepted
- `busy`  out  1  high from the cycle after start acceptance until the cycle before `done`
- `done`  out  1  one-cycle pulse: digest updated
- `digest`  out  [127:0]  MD5 output byte order, byte 0 of the hash in bits [127:120]

## Operation

- Message words: M[g] = byte-swap of `block_in[32g : 32g+31]`, g = 0..15. All 16 words are latched on start acceptance, so `block_in` may change afterwards.
- Chaining registers H0..H3:
  - IV = 67452301, efcdab89, 98badcfe, 10325476.
  - Working registers A..D load from IV when `first_block`=1, or from H0..H3 when `first_block`=0.
- State machine:
  - IDLE: `ready`=1. On `start`, latch M, load A..D, set step counter i=0, go to ROUND.
  - ROUND: perform step i, i += 1. After step 63, go to ADD.
    - F/G/H/I function, message index g, shift s[i] and K[i] follow RFC 1321.
    - Each step: A,B,C,D <= D, B + rotl(A + f + K[i] + M[g], s[i]), B, C.
    - Step counter is 6 bits and wraps naturally; it is not used outside ROUND.
  - ADD: Hn <= base_n + working_n (mod 2^32), where base is IV or the old H as chosen at start. Pulse `done`, go to IDLE.
- `digest` = {bswap(H0), bswap(H1), bswap(H2), bswap(H3)} and is updated only in ADD.
- Boundary conditions:
  - `start` while not `ready`: ignored, no queuing.
  - `start` in the same cycle as `done`: accepted, because the block is in IDLE.
  - `first_block`=0 on the very first block after reset: chains from H = IV, which gives the same result as `first_block`=1.
- Reset, at any time including mid-ROUND:
  - State returns to IDLE.
  - `ready`=1, `busy`=0, `done`=0.
  - H = IV, so `digest` = 0123456789abcdeffedcba9876543210.
  - Working registers and M are cleared to 0.
  - Any in-flight block is discarded.

## Timing

- Start sampled at edge N:
  - ROUND occupies cycles N+1..N+64.
  - ADD occupies cycle N+65.
  - `done`=1 and the new `digest` are visible in cycle N+66.
- Throughput: one block per 66 cycles with back-to-back starts.
- All outputs are registered. Each ROUND cycle's critical path is one adder chain of four 32-bit adds plus a rotate.

## Configuration

- `MD5_UNROLL2_EN` defined: two steps per ROUND cycle (i and i+1, i even), and the counter advances by 2.
  - ROUND occupies N+1..N+32, ADD N+33, `done` in N+34.
  - Digests are bit-identical to the undefined build.
- Undefined: one step per cycle, with the timing given above.

## Structure

- Package `md5_pkg`:
  - K[0:63] table
  - shift table s[0:63]
  - IV constants
  - state enum (IDLE, ROUND, ADD)
  - bswap32 and message-index function g(i)
- Sub-module `md5_step`: purely combinational single MD5 step (inputs A,B,C,D, M[g], i; outputs next A..D). Instantiated once, or twice in cascade under `MD5_UNROLL2_EN`.

## Test plan

- Empty message: block = 80 followed by zeros, length 0, `first_block`=1 -> `digest` = d41d8cd98f00b204e9800998ecf8427e; `done` in cycle N+66 (N+34 with macro).
- "abc": bytes 61 62 63 80, byte 56 = 18 -> `digest` = 900150983cd24fb0d6963f7d28e17f72.
- 80-character "1234567890"×8, two blocks, second with `first_block`=0 issued in the `done` cycle -> 57edf4a22be3c955ac49da2e2107b67a.
- `start` pulsed every cycle during ROUND with a different block -> ignored; digest still matches the first block; `ready`=0 throughout.
- `rst_n` low at cycle N+30 -> `busy`=0, `ready`=1, `done`=0 immediately, `digest` = 0123456789abcdeffedcba9876543210; the next "abc" block hashes correctly.
- Two consecutive `first_block`=1 "abc" blocks -> both produce 900150983cd24fb0d6963f7d28e17f72, with no chaining leakage.

Source files
------------

// File: rtl/md5_pkg.sv
// MD5 constants and helpers: round constants, shift schedule, IV, FSM states, byte swap, message index.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package md5_pkg;

    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hefcdab89;
    localparam logic [31:0] IV2 = 32'h98badcfe;
    localparam logic [31:0] IV3 = 32'h10325476;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_ADD   = 2'd2
    } state_e;

    localparam logic [31:0] K_TAB [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Message word used by step i; all arithmetic is naturally mod 16.
    function automatic logic [3:0] msg_idx(input logic [5:0] i);
        logic [3:0] g;
        g = i[3:0];
        case (i[5:4])
            2'd0:    g = i[3:0];
            2'd1:    g = i[3:0] * 4'd5 + 4'd1;
            2'd2:    g = i[3:0] * 4'd3 + 4'd5;
            default: g = i[3:0] * 4'd7;
        endcase
        return g;
    endfunction

    // Left-rotate amount: four values per round, cycling with i mod 4.
    function automatic logic [4:0] shift_amt(input logic [5:0] i);
        logic [4:0] s;
        s = 5'd0;
        case ({i[5:4], i[1:0]})
            4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
            4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
            4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
            4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  default: s = 5'd21;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/md5_step.sv
// One MD5 step: round function, constant add, rotate, rotate-in of the working registers.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to register it.
import md5_pkg::*;

module md5_step (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [31:0] m_i,
    input  logic [5:0]  idx_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);

    logic [31:0] f;
    logic [31:0] sum;

    // Round-dependent boolean function F/G/H/I, then the four-way add and rotate.
    always_comb begin
        f = 32'd0;
        case (idx_i[5:4])
            2'd0:    f = (b_i & c_i) | (~b_i & d_i);
            2'd1:    f = (b_i & d_i) | (c_i & ~d_i);
            2'd2:    f = b_i ^ c_i ^ d_i;
            default: f = c_i ^ (b_i | ~d_i);
        endcase
        sum = a_i + f + K_TAB[idx_i] + m_i;
        a_o = d_i;
        b_o = b_i + rotl32(sum, shift_amt(idx_i));
        c_o = b_i;
        d_o = c_i;
    end

endmodule

// File: rtl/md5_compress.sv
// Iterative MD5 compression of one 512-bit block into the 128-bit chaining state (MD5_UNROLL2_EN: two steps/cycle).
// Latency: done/digest 66 cycles after start is sampled (34 with MD5_UNROLL2_EN), one block per 66 (34) cycles.
// Backpressure: ready is low while a block is in flight; start without ready is dropped, never queued.
import md5_pkg::*;

module md5_compress (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         first_block,
    input  logic [0:511] block_in,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [127:0] digest
);

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] wa_q, wb_q, wc_q, wd_q;
    logic [31:0] wa_d, wb_d, wc_d, wd_d;
    logic [31:0] m_q [0:15];
    logic [31:0] m_d [0:15];
    logic [31:0] h_q [0:3];
    logic [31:0] h_d [0:3];
    logic        first_q, first_d;
    logic        done_q, done_d;

    logic [31:0] s0_a, s0_b, s0_c, s0_d;
    logic [31:0] r_a, r_b, r_c, r_d;
    logic        last_step;
    logic [5:0]  idx_inc;
    logic [31:0] m0;

    assign m0 = m_q[msg_idx(idx_q)];

    md5_step u_step0 (
        .a_i(wa_q), .b_i(wb_q), .c_i(wc_q), .d_i(wd_q),
        .m_i(m0), .idx_i(idx_q),
        .a_o(s0_a), .b_o(s0_b), .c_o(s0_c), .d_o(s0_d)
    );

`ifdef MD5_UNROLL2_EN
    // Second step of the pair always has an odd index since the counter stays even.
    logic [5:0]  idx1;
    logic [31:0] m1;
    assign idx1 = {idx_q[5:1], 1'b1};
    assign m1   = m_q[msg_idx(idx1)];

    md5_step u_step1 (
        .a_i(s0_a), .b_i(s0_b), .c_i(s0_c), .d_i(s0_d),
        .m_i(m1), .idx_i(idx1),
        .a_o(r_a), .b_o(r_b), .c_o(r_c), .d_o(r_d)
    );
    assign last_step = (idx_q == 6'd62);
    assign idx_inc   = 6'd2;
`else
    assign {r_a, r_b, r_c, r_d} = {s0_a, s0_b, s0_c, s0_d};
    assign last_step = (idx_q == 6'd63);
    assign idx_inc   = 6'd1;
`endif

    // Next-state: accept in IDLE, step through ROUND, fold into H in ADD.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        {wa_d, wb_d, wc_d, wd_d} = {wa_q, wb_q, wc_q, wd_q};
        m_d     = m_q;
        h_d     = h_q;
        first_d = first_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int g = 0; g < 16; g++) begin
                        m_d[g] = bswap32(block_in[32*g +: 32]);
                    end
                    if (first_block) begin
                        {wa_d, wb_d, wc_d, wd_d} = {IV0, IV1, IV2, IV3};
                    end else begin
                        {wa_d, wb_d, wc_d, wd_d} = {h_q[0], h_q[1], h_q[2], h_q[3]};
                    end
                    first_d = first_block;
                    idx_d   = 6'd0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                {wa_d, wb_d, wc_d, wd_d} = {r_a, r_b, r_c, r_d};
                idx_d = idx_q + idx_inc;
                if (last_step) begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                // H is untouched during ROUND, so the chaining base is still h_q here.
                h_d[0]  = (first_q ? IV0 : h_q[0]) + wa_q;
                h_d[1]  = (first_q ? IV1 : h_q[1]) + wb_q;
                h_d[2]  = (first_q ? IV2 : h_q[2]) + wc_q;
                h_d[3]  = (first_q ? IV3 : h_q[3]) + wd_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any block in flight and restores the IV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 6'd0;
            wa_q    <= 32'd0;
            wb_q    <= 32'd0;
            wc_q    <= 32'd0;
            wd_q    <= 32'd0;
            for (int g = 0; g < 16; g++) begin
                m_q[g] <= 32'd0;
            end
            h_q[0]  <= IV0;
            h_q[1]  <= IV1;
            h_q[2]  <= IV2;
            h_q[3]  <= IV3;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wa_q    <= wa_d;
            wb_q    <= wb_d;
            wc_q    <= wc_d;
            wd_q    <= wd_d;
            m_q     <= m_d;
            h_q     <= h_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    assign ready  = (state_q == ST_IDLE);
    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign digest = {bswap32(h_q[0]), bswap32(h_q[1]), bswap32(h_q[2]), bswap32(h_q[3])};

endmodule

// File: tb/tb_md5_compress.sv
// Directed checks of md5_compress against known MD5 digests, latency, flow control and reset.
// Latency: expects done 65 edges after the accepting edge (33 with MD5_UNROLL2_EN).
// Backpressure: drives start only while ready, except where ignored starts are deliberately exercised.
module tb_md5_compress;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         first_block;
    logic [0:511] block_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [127:0] digest;

`ifdef MD5_UNROLL2_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 65;
`endif

    localparam logic [127:0] IV_DIGEST  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] ABC_DIGEST = 128'h900150983cd24fb0d6963f7d28e17f72;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [0:511] blk;
        logic         first;
        logic [127:0] exp;
        string        name;
    } vec_t;

    vec_t vecs [0:3];

    md5_compress dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_block(first_block),
        .block_in(block_in), .ready(ready), .busy(busy), .done(done), .digest(digest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Single-block padding of a short ASCII message (length < 56 bytes).
    function automatic logic [0:511] pad1(input string s);
        logic [0:511] b;
        logic [63:0]  bits;
        int           n;
        b    = '0;
        n    = s.len();
        for (int k = 0; k < n; k++) b[8*k +: 8] = s[k];
        b[8*n +: 8] = 8'h80;
        bits = 64'(n) * 64'd8;
        for (int k = 0; k < 8; k++) b[8*(56+k) +: 8] = bits[8*k +: 8];
        return b;
    endfunction

    // Called at #1 after an edge while ready; returns #1 after the accepting edge.
    task automatic launch(input logic [0:511] b, input logic f);
        start       = 1'b1;
        first_block = f;
        block_in    = b;
        @(posedge clk); #1;
        start       = 1'b0;
        block_in    = ~b;
        chk("busy_ready_after_start", {126'd0, busy, ready}, 128'd2);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 128'd0, 128'd1);
    endtask

    initial begin
        int           lat;
        int           bad;
        logic [0:511] b1, b2;

        vecs[0].blk = pad1("abc");            vecs[0].first = 1'b0;
        vecs[0].exp = ABC_DIGEST;             vecs[0].name  = "abc_first0_after_reset";
        vecs[1].blk = pad1("");               vecs[1].first = 1'b1;
        vecs[1].exp = 128'hd41d8cd98f00b204e9800998ecf8427e; vecs[1].name = "empty";
        vecs[2].blk = pad1("a");              vecs[2].first = 1'b1;
        vecs[2].exp = 128'h0cc175b9c0f1b6a831c399e269772661; vecs[2].name = "a";
        vecs[3].blk = pad1("message digest"); vecs[3].first = 1'b1;
        vecs[3].exp = 128'hf96b697d7cb7938d525a2f31aaf161d0; vecs[3].name = "message_digest";

        rst_n = 1'b0; start = 1'b0; first_block = 1'b0; block_in = '0;
        #12;
        chk("rst_ready",  {127'd0, ready}, 128'd1);
        chk("rst_busy",   {127'd0, busy},  128'd0);
        chk("rst_done",   {127'd0, done},  128'd0);
        chk("rst_digest", digest, IV_DIGEST);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven single-block vectors.
        for (int v = 0; v < 4; v++) begin
            launch(vecs[v].blk, vecs[v].first);
            wait_done(lat);
            chk({vecs[v].name, "_digest"}, digest, vecs[v].exp);
            chk({vecs[v].name, "_latency"}, 128'(lat), 128'(LAT));
            @(posedge clk); #1;
            chk({vecs[v].name, "_done_pulse"}, {126'd0, done, ready}, 128'd1);
        end

        // Two-block "1234567890"x8, second block issued in the done cycle.
        b1 = '0; b2 = '0;
        for (int k = 0; k < 64; k++) b1[8*k +: 8] = 8'h30 + 8'((k + 1) % 10);
        for (int k = 0; k < 16; k++) b2[8*k +: 8] = 8'h30 + 8'((64 + k + 1) % 10);
        b2[8*16 +: 8] = 8'h80;
        b2[8*56 +: 8] = 8'h80;
        b2[8*57 +: 8] = 8'h02;
        launch(b1, 1'b1);
        wait_done(lat);
        chk("blk1_latency", 128'(lat), 128'(LAT));
        launch(b2, 1'b0);
        wait_done(lat);
        chk("blk2_latency", 128'(lat), 128'(LAT));
        chk("two_block_digest", digest, 128'h57edf4a22be3c955ac49da2e2107b67a);

        // Fresh first_block=1 after a non-IV state: no leakage, twice in a row.
        for (int r = 0; r < 2; r++) begin
            launch(pad1("abc"), 1'b1);
            wait_done(lat);
            chk("abc_repeat_digest", digest, ABC_DIGEST);
        end

        // start hammered during ROUND/ADD with other blocks must be ignored.
        launch(pad1("abc"), 1'b1);
        bad = 0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat   = c;
                start = 1'b0;
                break;
            end
            if (ready !== 1'b0) bad++;
            start       = 1'b1;
            first_block = 1'(c & 1);
            block_in    = pad1("") ^ {16{32'(c)}};
        end
        if (lat < 0) chk("ignore_timeout", 128'd0, 128'd1);
        chk("ready_low_in_flight", 128'(bad), 128'd0);
        chk("ignore_latency", 128'(lat), 128'(LAT));
        chk("ignore_digest", digest, ABC_DIGEST);
        repeat (3) @(posedge clk);
        #1;
        chk("no_queued_start", {126'd0, busy, ready}, 128'd1);

        // Asynchronous reset in cycle N+30 of an in-flight block.
        launch(pad1(""), 1'b1);
        repeat (29) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy",   {127'd0, busy},  128'd0);
        chk("midrst_ready",  {127'd0, ready}, 128'd1);
        chk("midrst_done",   {127'd0, done},  128'd0);
        chk("midrst_digest", digest, IV_DIGEST);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        launch(pad1("abc"), 1'b1);
        wait_done(lat);
        chk("post_rst_abc_digest", digest, ABC_DIGEST);
        chk("post_rst_latency", 128'(lat), 128'(LAT));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
